// File: rtl/ram_80x16_fifo_ctrl.sv
// FIFO controller mastering an external 80x16 pseudo-dual-port RAM macro, with a 2-entry output buffer.
// Optional idle retention/sleep sequencer is built when RAM_80X16_FIFO_SLEEP_EN is defined.
module ram_80x16_fifo_ctrl #(
  parameter int         DEPTH       = 80,
  parameter int         IDLE_CYCLES = 16,
  parameter int         WAKE_CYCLES = 2,
  parameter logic [7:0] SVOP_VAL    = 8'h00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_pvld,
  output logic        wr_prdy,
  input  logic [15:0] wr_pd,
  output logic        rd_pvld,
  input  logic        rd_prdy,
  output logic [15:0] rd_pd,
  input  logic        sleep_allow,
  output logic [6:0]  fifo_cnt,
  output logic        ram_we,
  output logic [6:0]  ram_wadr,
  output logic [15:0] ram_wd,
  output logic        ram_re,
  output logic [6:0]  ram_radr,
  input  logic [15:0] ram_rd,
  output logic [7:0]  ram_sleep_en,
  output logic        ram_ret_en,
  output logic        ram_iddq,
  output logic [7:0]  ram_svop
);

  localparam logic [6:0] DEPTH_W  = 7'(DEPTH);
  localparam logic [6:0] LAST_ADR = 7'(DEPTH - 1);

  logic [6:0]  wptr_reg, wptr_next;
  logic [6:0]  rptr_reg, rptr_next;
  logic [6:0]  ram_cnt_reg, ram_cnt_next;
  logic        inflight_reg;
  logic [1:0]  obuf_cnt_reg, obuf_cnt_next;
  logic        obuf_head_reg, obuf_head_next;
  logic [15:0] obuf_mem [2];
  logic [1:0]  obuf_we;
  logic        obuf_wr_idx;
  logic        active;
  logic        push;
  logic        pop;
  logic        re_issue;

  // Reset gates the handshakes combinationally so nothing moves while RST is held.
  assign wr_prdy  = ~RST & active & (ram_cnt_reg < DEPTH_W);
  assign push     = wr_pvld & wr_prdy;
  assign rd_pvld  = (obuf_cnt_reg != 2'd0);
  assign pop      = rd_pvld & rd_prdy;
  // Issue only if the buffer can absorb the returning word after this cycle's pop.
  assign re_issue = ~RST & active & (ram_cnt_reg != 7'd0) &
                    (({1'b0, obuf_cnt_reg} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop}));

  assign ram_we   = push;
  assign ram_wadr = wptr_reg;
  assign ram_wd   = push ? wr_pd : 16'h0000;
  assign ram_re   = re_issue;
  assign ram_radr = rptr_reg;
  assign ram_iddq = 1'b0;
  assign ram_svop = SVOP_VAL;

  assign rd_pd    = obuf_mem[obuf_head_reg];
  assign fifo_cnt = ram_cnt_reg + {6'b0, inflight_reg} + {5'b0, obuf_cnt_reg};

  assign obuf_wr_idx = obuf_head_reg ^ obuf_cnt_reg[0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_obuf_we
      assign obuf_we[gi] = inflight_reg & (obuf_wr_idx == 1'(gi));
    end
  endgenerate

  always_comb begin
    wptr_next = wptr_reg;
    if (push) wptr_next = (wptr_reg == LAST_ADR) ? 7'd0 : wptr_reg + 7'd1;
    rptr_next = rptr_reg;
    if (re_issue) rptr_next = (rptr_reg == LAST_ADR) ? 7'd0 : rptr_reg + 7'd1;
    ram_cnt_next   = ram_cnt_reg + {6'b0, push} - {6'b0, re_issue};
    obuf_cnt_next  = obuf_cnt_reg + {1'b0, inflight_reg} - {1'b0, pop};
    obuf_head_next = obuf_head_reg ^ pop;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_reg      <= 7'd0;
      rptr_reg      <= 7'd0;
      ram_cnt_reg   <= 7'd0;
      inflight_reg  <= 1'b0;
      obuf_cnt_reg  <= 2'd0;
      obuf_head_reg <= 1'b0;
      for (int i = 0; i < 2; i++) obuf_mem[i] <= 16'h0000;
    end else begin
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      ram_cnt_reg   <= ram_cnt_next;
      inflight_reg  <= re_issue;
      obuf_cnt_reg  <= obuf_cnt_next;
      obuf_head_reg <= obuf_head_next;
      for (int i = 0; i < 2; i++) begin
        if (obuf_we[i]) obuf_mem[i] <= ram_rd;
      end
    end
  end

`ifdef RAM_80X16_FIFO_SLEEP_EN
  typedef enum logic [1:0] {ST_ACTIVE, ST_RET, ST_SLEEP, ST_WAKE} state_t;

  localparam int             IW      = $clog2(IDLE_CYCLES + 1);
  localparam int             WW      = $clog2(WAKE_CYCLES + 1);
  localparam logic [IW-1:0]  IDLE_W  = IW'(IDLE_CYCLES);
  localparam logic [WW-1:0]  WAKE_LAST = WW'(WAKE_CYCLES - 1);

  state_t          state_reg, state_next;
  logic [IW-1:0]   idle_cnt_reg, idle_cnt_next;
  logic [WW-1:0]   wake_cnt_reg, wake_cnt_next;
  logic            idle_now;

  assign idle_now = ~wr_pvld & ~push & ~re_issue & ~inflight_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_ACTIVE;
      idle_cnt_reg <= '0;
      wake_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      idle_cnt_reg <= idle_cnt_next;
      wake_cnt_reg <= wake_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idle_cnt_next = '0;
    wake_cnt_next = '0;
    case (state_reg)
      ST_ACTIVE: begin
        if (idle_now) idle_cnt_next = (idle_cnt_reg == IDLE_W) ? idle_cnt_reg : idle_cnt_reg + 1'b1;
        if (sleep_allow && idle_now && (idle_cnt_reg == IDLE_W)) state_next = ST_RET;
      end
      ST_RET:   state_next = ST_SLEEP;
      ST_SLEEP: begin
        if (wr_pvld || !sleep_allow || ((ram_cnt_reg != 7'd0) && (obuf_cnt_reg < 2'd2)))
          state_next = ST_WAKE;
      end
      ST_WAKE: begin
        wake_cnt_next = wake_cnt_reg + 1'b1;
        if (wake_cnt_reg == WAKE_LAST) begin
          state_next    = ST_ACTIVE;
          wake_cnt_next = '0;
        end
      end
      default: state_next = ST_ACTIVE;
    endcase
  end

  always_comb begin
    active       = (state_reg == ST_ACTIVE);
    ram_sleep_en = 8'h00;
    ram_ret_en   = 1'b0;
    case (state_reg)
      ST_RET:   ram_ret_en = 1'b1;
      ST_SLEEP: begin
        ram_sleep_en = 8'hFF;
        ram_ret_en   = 1'b1;
      end
      ST_WAKE:  ram_ret_en = 1'b1;
      default:  ram_ret_en = 1'b0;
    endcase
  end
`else
  logic unused_sleep_allow;

  assign active             = 1'b1;
  assign ram_sleep_en       = 8'h00;
  assign ram_ret_en         = 1'b0;
  assign unused_sleep_allow = sleep_allow;
`endif

endmodule

// File: tb/tb_ram_80x16_fifo_ctrl.sv
// Directed bench for ram_80x16_fifo_ctrl with a behavioural model of the 80x16 RAM macro.
// Sleep-path sequence is selected by RAM_80X16_FIFO_SLEEP_EN, matching the RTL build.
module tb_ram_80x16_fifo_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        wr_pvld = 1'b0;
  logic        wr_prdy;
  logic [15:0] wr_pd = 16'h0000;
  logic        rd_pvld;
  logic        rd_prdy = 1'b0;
  logic [15:0] rd_pd;
  logic        sleep_allow = 1'b0;
  logic [6:0]  fifo_cnt;
  logic        ram_we;
  logic [6:0]  ram_wadr;
  logic [15:0] ram_wd;
  logic        ram_re;
  logic [6:0]  ram_radr;
  logic [15:0] ram_rd = 16'h0000;
  logic [7:0]  ram_sleep_en;
  logic        ram_ret_en;
  logic        ram_iddq;
  logic [7:0]  ram_svop;

  int checks = 0;
  int failures = 0;

  ram_80x16_fifo_ctrl dut (
    .CLK(CLK), .RST(RST),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .sleep_allow(sleep_allow), .fifo_cnt(fifo_cnt),
    .ram_we(ram_we), .ram_wadr(ram_wadr), .ram_wd(ram_wd),
    .ram_re(ram_re), .ram_radr(ram_radr), .ram_rd(ram_rd),
    .ram_sleep_en(ram_sleep_en), .ram_ret_en(ram_ret_en),
    .ram_iddq(ram_iddq), .ram_svop(ram_svop)
  );

  always #5 CLK = ~CLK;

  // RAM macro model: 1-cycle read latency, garbage on RD while asleep.
  logic [15:0] mem [128];
  always @(posedge CLK) begin
    if (ram_we) mem[ram_wadr] <= ram_wd;
    if (ram_sleep_en[7]) ram_rd <= 16'hBAD0;
    else if (ram_re) ram_rd <= mem[ram_radr];
  end

  typedef struct {
    logic        wr_pvld;
    logic [15:0] wr_pd;
    logic        rd_prdy;
    logic        e_wr_prdy;
    logic        e_we;
    logic [6:0]  e_wadr;
    logic [15:0] e_wd;
    logic        e_re;
    logic [6:0]  e_radr;
    logic        e_pvld;
    logic [15:0] e_pd;
    logic [6:0]  e_cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  task automatic push_n(input int n, input string tag);
    int acc = 0;
    for (int c = 0; c < 3 * n + 20 && acc < n; c++) begin
      wr_pvld = 1'b1;
      wr_pd = acc[15:0];
      @(negedge CLK);
      if (wr_prdy) acc++;
      cyc();
    end
    wr_pvld = 1'b0;
    chk({tag, "_accepts"}, acc, n);
    $display("push %s: %0d words accepted", tag, acc);
  endtask

  task automatic drain(input int first, input int n, input string tag);
    int got = 0;
    rd_prdy = 1'b1;
    for (int c = 0; c < 4 * n + 20 && got < n; c++) begin
      @(negedge CLK);
      if (rd_pvld) begin
        chk({tag, "_data"}, rd_pd, first + got);
        got++;
      end
      cyc();
    end
    rd_prdy = 1'b0;
    chk({tag, "_count"}, got, n);
    $display("drain %s: %0d words popped", tag, got);
  endtask

  initial begin
    int acc;
    int pushed, popped, reads;
    int n;
    logic found, prev_ret, prev_sleep;

    vecs[0]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 7'd0, 16'h1234, 1'b0, 7'd0, 1'b0, 16'h0000, 7'd0};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 7'd1, 16'h0000, 1'b1, 7'd0, 1'b0, 16'h0000, 7'd1};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 7'd1, 16'h0000, 1'b0, 7'd1, 1'b0, 16'h0000, 7'd1};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 7'd1, 16'h0000, 1'b0, 7'd1, 1'b1, 16'h1234, 7'd1};
    vecs[4]  = '{1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b1, 7'd1, 16'hAAAA, 1'b0, 7'd1, 1'b0, 16'h0000, 7'd0};
    vecs[5]  = '{1'b1, 16'hBBBB, 1'b0, 1'b1, 1'b1, 7'd2, 16'hBBBB, 1'b1, 7'd1, 1'b0, 16'h0000, 7'd1};
    vecs[6]  = '{1'b1, 16'hCCCC, 1'b0, 1'b1, 1'b1, 7'd3, 16'hCCCC, 1'b1, 7'd2, 1'b0, 16'h0000, 7'd2};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 7'd4, 16'h0000, 1'b0, 7'd3, 1'b1, 16'hAAAA, 7'd3};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 7'd4, 16'h0000, 1'b1, 7'd3, 1'b1, 16'hAAAA, 7'd3};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 7'd4, 16'h0000, 1'b0, 7'd4, 1'b1, 16'hBBBB, 7'd2};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 7'd4, 16'h0000, 1'b0, 7'd4, 1'b1, 16'hCCCC, 7'd1};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 7'd4, 16'h0000, 1'b0, 7'd4, 1'b0, 16'h0000, 7'd0};

    // Reset state, sampled while RST is still high.
    cyc();
    cyc();
    chk("rst_wr_prdy", wr_prdy, 0);
    chk("rst_rd_pvld", rd_pvld, 0);
    chk("rst_rd_pd", rd_pd, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_re", ram_re, 0);
    chk("rst_wadr", ram_wadr, 0);
    chk("rst_radr", ram_radr, 0);
    chk("rst_wd", ram_wd, 0);
    chk("rst_sleep_en", ram_sleep_en, 0);
    chk("rst_ret_en", ram_ret_en, 0);
    chk("rst_iddq", ram_iddq, 0);
    chk("rst_svop", ram_svop, 8'h00);
    RST = 1'b0;

    // Single push latency plus buffer fill/drain, one table row per cycle.
    for (int i = 0; i < 12; i++) begin
      wr_pvld = vecs[i].wr_pvld;
      wr_pd   = vecs[i].wr_pd;
      rd_prdy = vecs[i].rd_prdy;
      @(negedge CLK);
      chk($sformatf("v%0d_wr_prdy", i), wr_prdy, vecs[i].e_wr_prdy);
      chk($sformatf("v%0d_we", i), ram_we, vecs[i].e_we);
      chk($sformatf("v%0d_wadr", i), ram_wadr, vecs[i].e_wadr);
      chk($sformatf("v%0d_wd", i), ram_wd, vecs[i].e_wd);
      chk($sformatf("v%0d_re", i), ram_re, vecs[i].e_re);
      chk($sformatf("v%0d_radr", i), ram_radr, vecs[i].e_radr);
      chk($sformatf("v%0d_rd_pvld", i), rd_pvld, vecs[i].e_pvld);
      if (vecs[i].e_pvld) chk($sformatf("v%0d_rd_pd", i), rd_pd, vecs[i].e_pd);
      chk($sformatf("v%0d_fifo_cnt", i), fifo_cnt, vecs[i].e_cnt);
      $display("vec %0d: push=%0b pd=%h rdy=%0b -> we=%0b re=%0b pvld=%0b rd_pd=%h cnt=%0d",
               i, wr_pvld, wr_pd, rd_prdy, ram_we, ram_re, rd_pvld, rd_pd, fifo_cnt);
      cyc();
    end
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;

    // Fill to DEPTH+2 with the consumer stalled.
    do_reset();
    acc = 0;
    for (int c = 0; c < 100; c++) begin
      wr_pvld = 1'b1;
      wr_pd = acc[15:0];
      @(negedge CLK);
      if (wr_prdy) begin
        chk("fill_wadr", ram_wadr, acc % 80);
        acc++;
      end
      cyc();
    end
    @(negedge CLK);
    chk("fill_accepts", acc, 82);
    chk("fill_fifo_cnt", fifo_cnt, 82);
    chk("fill_wr_prdy", wr_prdy, 0);
    $display("fill: %0d words accepted, fifo_cnt=%0d", acc, fifo_cnt);
    cyc();
    // Push and pop together while the RAM is full: push stays blocked.
    rd_prdy = 1'b1;
    @(negedge CLK);
    chk("full_pushpop_prdy", wr_prdy, 0);
    chk("full_pushpop_pvld", rd_pvld, 1);
    chk("full_pushpop_pd", rd_pd, 0);
    cyc();
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    drain(1, 81, "fill_pop");
    chk("fill_empty_cnt", fifo_cnt, 0);

    // Sustained push+pop for 200 cycles, pointers wrap past 79.
    do_reset();
    pushed = 0;
    popped = 0;
    reads = 0;
    for (int c = 0; c < 200; c++) begin
      wr_pvld = 1'b1;
      wr_pd = pushed[15:0];
      rd_prdy = 1'b1;
      @(negedge CLK);
      chk("tp_wr_prdy", wr_prdy, 1);
      if (wr_prdy) begin
        chk("tp_wadr", ram_wadr, pushed % 80);
        pushed++;
      end
      if (ram_re) begin
        chk("tp_radr", ram_radr, reads % 80);
        reads++;
      end
      if (rd_pvld) begin
        chk("tp_data", rd_pd, popped);
        popped++;
      end
      cyc();
    end
    wr_pvld = 1'b0;
    chk("tp_pushed", pushed, 200);
    chk("tp_rate", popped >= 197, 1);
    $display("throughput: pushed=%0d popped=%0d reads=%0d", pushed, popped, reads);
    drain(popped, pushed - popped, "tp_tail");

    // Reset in the middle of a burst.
    do_reset();
    push_n(40, "mid");
    @(negedge CLK);
    chk("mid_fifo_cnt", fifo_cnt, 40);
    cyc();
    RST = 1'b1;
    cyc();
    chk("midrst_fifo_cnt", fifo_cnt, 0);
    chk("midrst_rd_pvld", rd_pvld, 0);
    chk("midrst_wadr", ram_wadr, 0);
    chk("midrst_radr", ram_radr, 0);
    chk("midrst_wr_prdy", wr_prdy, 0);
    chk("midrst_we", ram_we, 0);
    chk("midrst_re", ram_re, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_release_prdy", wr_prdy, 1);
    $display("mid-burst reset: fifo_cnt=%0d", fifo_cnt);
    cyc();

`ifdef RAM_80X16_FIFO_SLEEP_EN
    // 5 words in RAM + 2 in the buffer, then idle into retention.
    push_n(7, "slp");
    sleep_allow = 1'b1;
    found = 1'b0;
    prev_ret = 1'b0;
    prev_sleep = 1'b0;
    n = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge CLK);
      if (ram_sleep_en == 8'hFF) found = 1'b1;
      else begin
        prev_ret = ram_ret_en;
        prev_sleep = ram_sleep_en[0];
        n++;
      end
      cyc();
    end
    chk("slp_entered", found, 1);
    chk("slp_idle_wait", n >= 16, 1);
    chk("slp_ret_phase_ret", prev_ret, 1);
    chk("slp_ret_phase_sleep", prev_sleep, 0);
    @(negedge CLK);
    chk("slp_fifo_cnt", fifo_cnt, 7);
    chk("slp_ret_en", ram_ret_en, 1);
    chk("slp_sleep_en", ram_sleep_en, 8'hFF);
    chk("slp_wr_prdy", wr_prdy, 0);
    chk("slp_re", ram_re, 0);
    chk("slp_rd_pvld", rd_pvld, 1);
    $display("sleep entered after %0d idle cycles", n);
    cyc();
    rd_prdy = 1'b1;
    @(negedge CLK);
    chk("slp_pop_pd", rd_pd, 0);
    chk("slp_pop_sleep_en", ram_sleep_en, 8'hFF);
    cyc();
    rd_prdy = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 4 && !found; c++) begin
      @(negedge CLK);
      if (ram_sleep_en == 8'h00) found = 1'b1;
      else cyc();
    end
    chk("wake_entered", found, 1);
    chk("wake1_ret_en", ram_ret_en, 1);
    chk("wake1_wr_prdy", wr_prdy, 0);
    cyc();
    @(negedge CLK);
    chk("wake2_ret_en", ram_ret_en, 1);
    chk("wake2_sleep_en", ram_sleep_en, 8'h00);
    chk("wake2_wr_prdy", wr_prdy, 0);
    cyc();
    @(negedge CLK);
    chk("active_ret_en", ram_ret_en, 0);
    chk("active_wr_prdy", wr_prdy, 1);
    $display("wake complete, ret_en=%0b", ram_ret_en);
    cyc();
    drain(1, 6, "slp_pop");
    sleep_allow = 1'b0;
`else
    // Without the sequencer the macro must stay awake however long we idle.
    sleep_allow = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      chk("nosleep_sleep_en", ram_sleep_en, 8'h00);
      chk("nosleep_ret_en", ram_ret_en, 0);
      cyc();
    end
    @(negedge CLK);
    chk("nosleep_wr_prdy", wr_prdy, 1);
    $display("no-sleep build: idle 100 cycles, sleep_en=%h ret_en=%0b", ram_sleep_en, ram_ret_en);
    sleep_allow = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
